// File: rtl/seg7_spi_ctrl.sv
// seg7_spi_ctrl: byte-level command decoder for a 4-digit 7-segment display.
// Each byte received from the SPI slave is decoded and answered one cycle later.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_valid, rx_byte received byte strobe and data
//   cs_n              synchronised chip-select, 1 closes the frame
//   tx_valid, tx_byte response strobe and data (data held between strobes)
//   digit0..digit3    BCD display digits, digit0 least significant
//   colon             00 colon, 01 decimal point, 11 none
//   err_count         saturating count of rejected bytes
module seg7_spi_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       cs_n,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] colon,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {StIdle, StArg, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [1:0]  arg_cnt_q, arg_cnt_d;
  logic [7:0]  stage_q, stage_d;     // first arg of an all-digit write
  logic [17:0] rb_q, rb_d;           // {digits, colon} captured at a readback command
  logic [15:0] digits_q, digits_d;   // {d3, d2, d1, d0}
  logic [1:0]  colon_q, colon_d;
  logic [7:0]  err_q, err_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic [15:0] inc_digits;
  logic        carry;
  logic        err_inc;
  logic        reject;
  logic        lo_ok, hi_ok;

  assign lo_ok = (rx_byte[3:0] <= 4'd9);
  assign hi_ok = (rx_byte[7:4] <= 4'd9);

  // 4-digit BCD increment with ripple carry; 9999 wraps to 0000.
  always_comb begin
    inc_digits = digits_q;
    carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digits_q[4*i +: 4] == 4'd9) begin
          inc_digits[4*i +: 4] = 4'd0;
        end else begin
          inc_digits[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_cnt_d  = arg_cnt_q;
    stage_d    = stage_q;
    rb_d       = rb_q;
    digits_d   = digits_q;
    colon_d    = colon_q;
    tx_valid_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    err_inc    = 1'b0;
    reject     = 1'b0;

    if (cs_n) begin
      // Frame closed: drop any partial command, committed state is kept.
      state_d   = StIdle;
      arg_cnt_d = 2'd0;
      stage_d   = 8'h00;
    end else if (rx_valid) begin
      tx_valid_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          cmd_d     = rx_byte;
          tx_byte_d = 8'hA5;
          state_d   = StArg;
          if (rx_byte[7:2] == 6'b000100) begin
            arg_cnt_d = 2'd1;
          end else if (rx_byte == 8'h20) begin
            arg_cnt_d = 2'd1;
          end else if (rx_byte == 8'h30) begin
            arg_cnt_d = 2'd2;
          end else if (rx_byte == 8'h40) begin
            arg_cnt_d = 2'd3;
            rb_d      = {digits_q, colon_q};
          end else if (rx_byte == 8'h50) begin
            digits_d = inc_digits;
            state_d  = StDone;
          end else begin
            err_inc   = 1'b1;
            tx_byte_d = 8'hEE;
            state_d   = StDone;
          end
        end
        StArg: begin
          arg_cnt_d = arg_cnt_q - 2'd1;
          tx_byte_d = rx_byte;
          if (arg_cnt_q == 2'd1) state_d = StDone;
          if (cmd_q[7:2] == 6'b000100) begin
            if (!lo_ok) reject = 1'b1;
            else digits_d[{cmd_q[1:0], 2'b00} +: 4] = rx_byte[3:0];
          end else if (cmd_q == 8'h20) begin
            colon_d = rx_byte[1:0];
          end else if (cmd_q == 8'h30) begin
            if (!lo_ok || !hi_ok) reject = 1'b1;
            else if (arg_cnt_q == 2'd2) stage_d = rx_byte;
            else digits_d = {stage_q, rx_byte};
          end else if (cmd_q == 8'h40) begin
            if (arg_cnt_q == 2'd3)      tx_byte_d = rb_q[17:10];
            else if (arg_cnt_q == 2'd2) tx_byte_d = rb_q[9:2];
            else                        tx_byte_d = {6'b0, rb_q[1:0]};
          end
          if (reject) begin
            err_inc   = 1'b1;
            tx_byte_d = 8'hEE;
            state_d   = StDone;
          end
        end
        StDone: begin
          tx_byte_d = 8'hFF;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= 8'h00;
      arg_cnt_q  <= 2'd0;
      stage_q    <= 8'h00;
      rb_q       <= '0;
      digits_q   <= 16'h0000;
      colon_q    <= 2'b11;
      err_q      <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_cnt_q  <= arg_cnt_d;
      stage_q    <= stage_d;
      rb_q       <= rb_d;
      digits_q   <= digits_d;
      colon_q    <= colon_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;
  assign digit0    = digits_q[3:0];
  assign digit1    = digits_q[7:4];
  assign digit2    = digits_q[11:8];
  assign digit3    = digits_q[15:12];
  assign colon     = colon_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_seg7_spi_ctrl.sv
// Scoreboard bench for seg7_spi_ctrl: a frame-level reference model predicts each
// response byte and the display state that goes with it; a monitor checks them.
module tb_seg7_spi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       cs_n = 1'b1;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] colon;
  logic [7:0] err_count;

  seg7_spi_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .cs_n      (cs_n),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .colon     (colon),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tx;
    logic [15:0] dig;
    logic [1:0]  col;
    logic [7:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Reference model: display value as a plain integer, frame as a byte list.
  int         m_val;
  logic [1:0] m_col;
  int         m_err;
  int         m_rb_val;
  logic [1:0] m_rb_col;
  bit         m_dead;
  logic [7:0] m_frame[$];
  int         pw[4] = '{1, 10, 100, 1000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int nargs(input logic [7:0] c);
    if (c >= 8'h10 && c <= 8'h13) return 1;
    if (c == 8'h20) return 1;
    if (c == 8'h30) return 2;
    if (c == 8'h40) return 3;
    if (c == 8'h50) return 0;
    return -1;
  endfunction

  function automatic void model_reset();
    m_val = 0; m_col = 2'b11; m_err = 0; m_rb_val = 0; m_rb_col = 2'b00;
    m_dead = 1'b0; m_frame.delete();
  endfunction

  function automatic logic [7:0] model_reject();
    m_dead = 1'b1;
    if (m_err < 255) m_err++;
    return 8'hEE;
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] b);
    int pos, k, hi, lo;
    logic [7:0] c;
    m_frame.push_back(b);
    pos = m_frame.size() - 1;
    c   = m_frame[0];
    hi  = int'(b[7:4]);
    lo  = int'(b[3:0]);
    if (pos == 0) begin
      if (nargs(b) < 0) return model_reject();
      if (b == 8'h50) m_val = (m_val + 1) % 10000;
      if (b == 8'h40) begin m_rb_val = m_val; m_rb_col = m_col; end
      return 8'hA5;
    end
    if (m_dead || pos > nargs(c)) return 8'hFF;
    if (nargs(c) == 1 && c != 8'h20) begin
      if (lo > 9) return model_reject();
      k = int'(c[1:0]);
      m_val = m_val - ((m_val / pw[k]) % 10) * pw[k] + lo * pw[k];
      return b;
    end
    if (c == 8'h20) begin m_col = b[1:0]; return b; end
    if (c == 8'h30) begin
      if (hi > 9 || lo > 9) return model_reject();
      if (pos == 2)
        m_val = int'(m_frame[1][7:4]) * 1000 + int'(m_frame[1][3:0]) * 100 + hi * 10 + lo;
      return b;
    end
    // readback
    if (pos == 1) return {4'((m_rb_val / 1000) % 10), 4'((m_rb_val / 100) % 10)};
    if (pos == 2) return {4'((m_rb_val / 10) % 10), 4'(m_rb_val % 10)};
    return {6'b0, m_rb_col};
  endfunction

  // One clock of stimulus; called aligned to 1 time unit after a rising edge.
  task automatic cyc(input bit v, input logic [7:0] b, input bit cs);
    exp_t e;
    rx_valid = v; rx_byte = b; cs_n = cs;
    if (cs) begin
      m_frame.delete(); m_dead = 1'b0;
    end else if (v) begin
      e.tx = model_byte(b);
      e.dig = to_bcd(m_val); e.col = m_col; e.err = 8'(m_err);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) cyc(1'b1, bytes[i], 1'b0);
    cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_byte"}, 32'(tx_byte), 32'h00);
    check({tag, "_digits"}, 32'({digit3, digit2, digit1, digit0}), 32'h0000);
    check({tag, "_colon"}, 32'(colon), 32'h3);
    check({tag, "_err"}, 32'(err_count), 32'h00);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_digits"}, 32'({digit3, digit2, digit1, digit0}), 32'(to_bcd(m_val)));
    check({tag, "_colon"}, 32'(colon), 32'(m_col));
    check({tag, "_err"}, 32'(err_count), 32'(m_err));
  endtask

  // Monitor: every response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && tx_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_tx: got tx_byte %0h with no byte pending at %0t",
                 tx_byte, $time);
      end else begin
        exp_exp_pop();
      end
    end
  end

  task automatic exp_exp_pop();
    exp_t e;
    e = exp_q.pop_front();
    check("tx_byte", 32'(tx_byte), 32'(e.tx));
    check("digits", 32'({digit3, digit2, digit1, digit0}), 32'(e.dig));
    check("colon", 32'(colon), 32'(e.col));
    check("err_count", 32'(err_count), 32'(e.err));
  endtask

  initial begin
    logic [7:0] bl[$];
    logic [7:0] cmds[9] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h30, 8'h40, 8'h50, 8'h7E};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);

    // Single digit write, all-digit write, aborted all-digit write.
    frame('{8'h12, 8'h07});
    frame('{8'h30, 8'h12, 8'h34});
    check("write_all", 32'({digit3, digit2, digit1, digit0}), 32'h1234);
    frame('{8'h30, 8'h56});
    check("aborted_write", 32'({digit3, digit2, digit1, digit0}), 32'h1234);

    // Readback with decimal point.
    frame('{8'h20, 8'h01});
    frame('{8'h40, 8'h00, 8'h11, 8'h22, 8'h33});

    // Increment wrap.
    frame('{8'h30, 8'h99, 8'h99});
    frame('{8'h50, 8'h00});
    check("inc_wrap", 32'({digit3, digit2, digit1, digit0}), 32'h0000);

    // Bad command, bad nibble.
    frame('{8'h7E});
    frame('{8'h11, 8'h0C, 8'h05});

    // Reset in the middle of an all-digit write.
    cyc(1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame('{8'h34, 8'h56});
    frame('{8'h20, 8'h00});
    check("colon_after_reset", 32'(colon), 32'h0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) frame('{8'($urandom_range(8'h60, 8'hFF))});
    check("err_saturate", 32'(err_count), 32'hFF);
    model_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomised frames with gaps and short/long frames.
    for (int f = 0; f < 300; f++) begin
      bl.delete();
      if ($urandom_range(0, 9) == 0) bl.push_back(8'($urandom));
      else bl.push_back(cmds[$urandom_range(0, 8)]);
      for (int a = 0; a < int'($urandom_range(0, 4)); a++) begin
        if ($urandom_range(0, 3) != 0)
          bl.push_back({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
        else bl.push_back(8'($urandom));
      end
      foreach (bl[i]) begin
        cyc(1'b1, bl[i], 1'b0);
        if ($urandom_range(0, 3) == 0) cyc(1'b0, 8'($urandom), 1'b0);
      end
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    end

    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    check("pending_tx", 32'(exp_q.size()), 32'd0);
    check_state("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
